// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for pipe_stage_buffer: upstream in_* and downstream out_*.
// Ports (signals): in_valid/in_ready/in_data/in_reg_addr/in_ctrl,
//   out_valid/out_ready/out_data/out_reg_addr/out_ctrl.
//   master = surrounding pipeline, slave = the buffer itself.
interface pipe_stage_buffer_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 5,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [ADDR_W-1:0]       in_reg_addr;
    logic [CTRL_W-1:0]       in_ctrl;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [ADDR_W-1:0]       out_reg_addr;
    logic [CTRL_W-1:0]       out_ctrl;

    modport master (
        output in_valid, in_data, in_reg_addr, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_reg_addr, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_reg_addr, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_reg_addr, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Generic inter-stage pipeline buffer: main + skid entry, valid/ready, flush.
// Ports: CLK, RSTn (async active-low), flush, bus (pipe_stage_buffer_if.slave);
//   with PIPE_STAGE_PERF_CNT_EN defined also stall_cnt[31:0], bubble_cnt[31:0].
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 5,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 6
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               flush,
    pipe_stage_buffer_if.slave bus
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    localparam int W = LANES * DATA_W;

    // bit0 = main valid, bit1 = skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_pop;
    logic                w_main_ld;
    logic                w_skid_ld;
    logic                w_move;

    logic [W-1:0]        r_main_data;
    logic [ADDR_W-1:0]   r_main_addr;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [W-1:0]        r_skid_data;
    logic [ADDR_W-1:0]   r_skid_addr;
    logic [CTRL_W-1:0]   r_skid_ctrl;

    // in_ready comes straight off the skid-valid flop
    assign bus.in_ready     = ~r_state[1];
    assign bus.out_valid    = r_state[0];
    assign bus.out_data     = r_main_data;
    assign bus.out_reg_addr = r_main_addr;
    // a bubble must never raise MemWrite/RegWrite downstream
    assign bus.out_ctrl     = r_main_ctrl & {CTRL_W{r_state[0]}};

    assign w_accept = bus.in_valid & ~r_state[1];
    assign w_pop    = r_state[0] & bus.out_ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_skid_ld   = 1'b0;
        w_move      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_ld   = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_ld   = 1'b1;
                    end else if (w_accept) begin
                        w_skid_ld   = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_move      = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_main_data <= '0;
            r_main_addr <= '0;
            r_main_ctrl <= '0;
        end else if (w_main_ld) begin
            r_main_data <= bus.in_data;
            r_main_addr <= bus.in_reg_addr;
            r_main_ctrl <= bus.in_ctrl;
        end else if (w_move) begin
            r_main_data <= r_skid_data;
            r_main_addr <= r_skid_addr;
            r_main_ctrl <= r_skid_ctrl;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_ctrl <= '0;
        end else if (w_skid_ld) begin
            r_skid_data <= bus.in_data;
            r_skid_addr <= bus.in_reg_addr;
            r_skid_ctrl <= bus.in_ctrl;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_state[0] && !bus.out_ready && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_state[0] && r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor of the EX-to-MEM stage register: a generic inter-stage buffer for any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries LANES data words, a register-write address and a control bundle, and adds a valid/ready handshake with a 2-entry skid, synchronous flush, and bubble gating of control outputs.
- Lets hazard logic stall or squash a stage without corrupting downstream control signals.

Parameters:
DATA_W, 32, width of each data lane
LANES, 5, number of data lanes (e.g. ALU result, read data, next PC, branch addr, jump addr)
ADDR_W, 5, register-write address width
CTRL_W, 6, control bundle width (e.g. MemWrite, MemRead, MemToReg, PCSrc, JToPC, RegWrite)

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  buffer can accept an entry this cycle
in_data  in  LANES*DATA_W  packed data lanes, lane 0 in LSBs
in_reg_addr  in  ADDR_W  register-write address
in_ctrl  in  CTRL_W  control bundle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head this cycle
out_data  out  LANES*DATA_W  head data lanes
out_reg_addr  out  ADDR_W  head register-write address
out_ctrl  out  CTRL_W  head control bundle, gated by out_valid

Behaviour:
- Storage: main entry (head) and skid entry, each with a valid bit. Occupancy states: EMPTY (0), ONE (main only), FULL (main + skid).
- in_ready = !skid_valid, driven directly from a register. It is 1 in EMPTY and ONE, 0 in FULL. No combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Transitions, absent flush:
  - EMPTY, accept → ONE; the entry is visible on the outputs in the next cycle (1-cycle latency).
  - ONE, accept & pop → ONE; main loads the new entry.
  - ONE, accept & !pop → FULL; the new entry goes to skid.
  - ONE, pop & !accept → EMPTY.
  - FULL, pop → ONE; skid moves to main and skid_valid clears. in_valid is ignored because in_ready = 0.
  - All other cases hold state.
- Ordering is strictly FIFO. Throughput is 1 entry/cycle when out_ready is held at 1.
- out_valid = main_valid. out_data and out_reg_addr present main contents regardless of valid.
- out_ctrl = main_ctrl AND'ed with out_valid per bit. A bubble never asserts MemWrite/RegWrite downstream.
- flush (synchronous, highest priority):
  - Next cycle: main_valid = skid_valid = 0, i.e. EMPTY.
  - An entry offered the same cycle is discarded even though in_ready was 1.
  - A pop in the flush cycle still counts as consumed downstream.
  - Data registers are not cleared.
- Reset (RSTn = 0, async, any time including mid-transfer): both valid bits = 0, all data/addr/ctrl registers = 0. Therefore out_valid = 0, out_ctrl = 0, out_data = 0, out_reg_addr = 0, in_ready = 1. After release, the first accepting edge behaves as EMPTY.
- Data registers load only on their own write enable, so there is no spurious toggling in hold.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- With it defined:
  - Adds outputs stall_cnt [31:0] and bubble_cnt [31:0], reset to 0 by RSTn.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 32'hFFFFFFFF; neither is affected by flush.
- Without it: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset mid-stream: fill to FULL, assert RSTn = 0 asynchronously → out_valid = 0, out_ctrl = 6'b0, in_ready = 1 immediately. After release, push lane0 = 32'h11 → it appears next cycle.
2. Streaming: out_ready = 1, push entries lane0 = 1..8 on consecutive cycles → outputs 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
3. Backpressure/skid: out_ready = 0, push A = 32'hA, B = 32'hB → state FULL, in_ready = 0, C held upstream. Raise out_ready → A, B, C emitted in order with no loss or duplication.
4. Flush with simultaneous input: FULL with ctrl = 6'b100001, assert flush with in_valid = 1 (in_ready = 0), then flush again from ONE with in_valid = 1 → out_valid = 0 and out_ctrl = 0 the next cycle; the flushed-cycle input never appears.
5. Bubble gating: EMPTY with stale main_ctrl = 6'b111111 → out_ctrl = 0 while out_valid = 0.
6. With PIPE_STAGE_PERF_CNT_EN: hold out_ready = 0 for 5 cycles with the head valid, then 3 empty cycles → stall_cnt = 5, bubble_cnt includes those 3 cycles; flush leaves both counters unchanged.
